// File: rtl/song_reader.sv
// ============================================================================
// Module      : song_reader
// Description : Walks the selected song's note ROM, one note per note_done,
//               strobing each note to the note player and flagging song end.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module song_reader #(
    parameter int NOTE_W = 6,
    parameter int DUR_W  = 6,
    parameter int IDX_W  = 5
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    play,
    input  logic                    reset_player,
    input  logic [1:0]              song,
    output logic [IDX_W+1:0]        rom_addr,
    input  logic [NOTE_W+DUR_W-1:0] rom_data,
    input  logic                    note_done,
    output logic                    new_note,
    output logic [NOTE_W-1:0]       note,
    output logic [DUR_W-1:0]        duration,
    output logic                    song_done
);

    localparam logic [2:0] c_idle  = 3'd0;
    localparam logic [2:0] c_fetch = 3'd1;
    localparam logic [2:0] c_latch = 3'd2;
    localparam logic [2:0] c_play  = 3'd3;
    localparam logic [2:0] c_done  = 3'd4;

    localparam logic [IDX_W-1:0] c_last_idx = {IDX_W{1'b1}};
    localparam logic [IDX_W-1:0] c_idx_one  = IDX_W'(1);

    logic [2:0]        r_state;
    logic [2:0]        w_state;
    logic [IDX_W-1:0]  r_index;
    logic [IDX_W-1:0]  w_index;
    logic [NOTE_W-1:0] r_note;
    logic [NOTE_W-1:0] w_note;
    logic [DUR_W-1:0]  r_duration;
    logic [DUR_W-1:0]  w_duration;
    logic              r_new_note;
    logic              w_new_note;
    logic              w_end_marker;

    assign w_end_marker = (rom_data == '0);

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= c_idle;
            r_index    <= '0;
            r_note     <= '0;
            r_duration <= '0;
            r_new_note <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_index    <= w_index;
            r_note     <= w_note;
            r_duration <= w_duration;
            r_new_note <= w_new_note;
        end
    end

    // Next-state logic; reset_player overrides every transition
    always_comb begin
        w_state = r_state;
        if (reset_player) begin
            w_state = c_idle;
        end else begin
            case (r_state)
                c_idle:  w_state = play ? c_fetch : c_idle;
                c_fetch: w_state = c_latch;
                c_latch: w_state = w_end_marker ? c_done : c_play;
                c_play: begin
                    if (note_done) begin
                        if (r_index == c_last_idx) begin
                            w_state = c_done;
                        end else begin
                            w_state = play ? c_fetch : c_idle;
                        end
                    end
                end
                c_done:  w_state = c_idle;
                default: w_state = c_idle;
            endcase
        end
    end

    // Datapath next values; index only wraps through DONE, never by overflow
    always_comb begin
        w_index    = r_index;
        w_note     = r_note;
        w_duration = r_duration;
        w_new_note = 1'b0;
        if (reset_player) begin
            w_index    = '0;
            w_note     = '0;
            w_duration = '0;
        end else begin
            case (r_state)
                c_latch: begin
                    if (!w_end_marker) begin
                        w_note     = rom_data[NOTE_W+DUR_W-1:DUR_W];
                        w_duration = rom_data[DUR_W-1:0];
                        w_new_note = 1'b1;
                    end
                end
                c_play: begin
                    if (note_done && (r_index != c_last_idx)) begin
                        w_index = r_index + c_idx_one;
                    end
                end
                c_done:  w_index = '0;
                default: ;
            endcase
        end
    end

    assign rom_addr  = {song, r_index};
    assign new_note  = r_new_note;
    assign note      = r_note;
    assign duration  = r_duration;
    assign song_done = (r_state == c_done);

endmodule

`default_nettype wire

// File: tb/tb_song_reader.sv
// ============================================================================
// Module      : tb_song_reader
// Description : Randomised scoreboard bench for song_reader with a ROM model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_song_reader;

    localparam int NOTE_W = 6;
    localparam int DUR_W  = 6;
    localparam int IDX_W  = 5;
    localparam int NOTES  = 1 << IDX_W;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              play;
    logic              reset_player;
    logic [1:0]        song;
    logic [IDX_W+1:0]  rom_addr;
    logic [11:0]       rom_data;
    logic              note_done;
    logic              new_note;
    logic [NOTE_W-1:0] note;
    logic [DUR_W-1:0]  duration;
    logic              song_done;

    logic [11:0] rom [0:4*NOTES-1];

    typedef struct {
        bit       is_done;
        int       n;
        int       d;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;
    int  n_checks = 0;
    int  n_fail   = 0;

    song_reader #(.NOTE_W(NOTE_W), .DUR_W(DUR_W), .IDX_W(IDX_W)) dut (
        .clk(clk), .reset_n(reset_n), .play(play), .reset_player(reset_player),
        .song(song), .rom_addr(rom_addr), .rom_data(rom_data),
        .note_done(note_done), .new_note(new_note), .note(note),
        .duration(duration), .song_done(song_done)
    );

    always #5 clk = ~clk;

    // Registered ROM: data valid one cycle after address
    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every strobe must match the head of the expected queue
    always @(negedge clk) begin
        if (reset_n && (new_note || song_done)) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_event: new_note=%0d song_done=%0d, expected nothing", new_note, song_done);
            end else begin
                mon_e = exp_q.pop_front();
                check("event_is_done", int'(song_done), int'(mon_e.is_done));
                if (new_note && !mon_e.is_done) begin
                    check("note", int'(note), mon_e.n);
                    check("duration", int'(duration), mon_e.d);
                end
            end
        end
    end

    task automatic fill_song(input int s, input int marker_at);
        for (int i = 0; i < NOTES; i++) begin
            rom[s*NOTES+i] = {6'($urandom_range(1, 63)), 6'($urandom_range(0, 63))};
        end
        if (marker_at >= 0) rom[s*NOTES+marker_at] = 12'd0;
    endtask

    task automatic change_song(input int s);
        @(negedge clk);
        song = 2'(s);
        reset_player = 1'b1;
        @(negedge clk);
        reset_player = 1'b0;
    endtask

    // Reference: the song is the ROM words in order until a zero word or 32 notes
    task automatic expect_song(input int s, input int mode, input int stop_idx);
        ev_t e;
        for (int i = 0; i < NOTES; i++) begin
            if (rom[s*NOTES+i] == 12'd0) begin
                e.is_done = 1'b1; e.n = 0; e.d = 0;
                exp_q.push_back(e);
                break;
            end
            e.is_done = 1'b0;
            e.n = int'(rom[s*NOTES+i][11:6]);
            e.d = int'(rom[s*NOTES+i][5:0]);
            exp_q.push_back(e);
            if (mode != 0 && i == stop_idx) break;
            if (i == NOTES-1) begin
                e.is_done = 1'b1; e.n = 0; e.d = 0;
                exp_q.push_back(e);
            end
        end
    endtask

    // mode 0: play to end; 1: reset_player with note_done at stop_idx;
    // 2: asynchronous reset while holding note stop_idx
    task automatic run_song(input int s, input int mode, input int stop_idx, input int pause_idx);
        int  idx = 0;
        int  t   = 0;
        bit  fin = 1'b0;
        expect_song(s, mode, stop_idx);
        @(negedge clk);
        play = 1'b1;
        while (!fin) begin
            while (!new_note && !song_done && t < 200) begin
                @(negedge clk);
                t++;
            end
            if (t >= 200) begin
                n_checks++;
                n_fail++;
                $display("FAIL wait_event: no new_note/song_done after %0d cycles", t);
                fin = 1'b1;
            end else if (song_done) begin
                play = 1'b0;
                reset_player = 1'b1;
                @(negedge clk);
                reset_player = 1'b0;
                check("idle_addr_after_done", int'(rom_addr), s*NOTES);
                check("no_note_after_done", int'(new_note), 0);
                fin = 1'b1;
            end else begin
                check("note_latency", t, 3);
                if (mode == 2 && idx == stop_idx) begin
                    #2 reset_n = 1'b0;
                    #1;
                    check("async_note", int'(note), 0);
                    check("async_duration", int'(duration), 0);
                    check("async_new_note", int'(new_note), 0);
                    check("async_addr", int'(rom_addr), s*NOTES);
                    exp_q.delete();
                    @(negedge clk);
                    play = 1'b0;
                    reset_n = 1'b1;
                    fin = 1'b1;
                end else begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    note_done = 1'b1;
                    if (mode == 1 && idx == stop_idx) reset_player = 1'b1;
                    if (idx == pause_idx) play = 1'b0;
                    @(negedge clk);
                    note_done = 1'b0;
                    t = 1;
                    if (mode == 1 && idx == stop_idx) begin
                        reset_player = 1'b0;
                        play = 1'b0;
                        check("rp_note", int'(note), 0);
                        check("rp_duration", int'(duration), 0);
                        check("rp_new_note", int'(new_note), 0);
                        check("rp_song_done", int'(song_done), 0);
                        check("rp_addr", int'(rom_addr), s*NOTES);
                        repeat (6) @(negedge clk);
                        fin = 1'b1;
                    end else if (idx == pause_idx && !song_done) begin
                        repeat (5) @(negedge clk);
                        check("paused_addr", int'(rom_addr), s*NOTES + idx + 1);
                        play = 1'b1;
                        t = 0;
                    end
                    idx++;
                end
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        play = 1'b0;
        reset_player = 1'b0;
        note_done = 1'b0;
        song = 2'd2;
        for (int i = 0; i < 4*NOTES; i++) rom[i] = 12'd0;
        repeat (3) @(negedge clk);
        check("reset_note", int'(note), 0);
        check("reset_duration", int'(duration), 0);
        check("reset_new_note", int'(new_note), 0);
        check("reset_song_done", int'(song_done), 0);
        reset_n = 1'b1;
        @(negedge clk);
        check("reset_addr", int'(rom_addr), 64);

        // Single note {5,10} then end marker on song 2
        rom[64] = {6'd5, 6'd10};
        run_song(2, 0, 0, -1);

        // Three notes then marker on song 1
        fill_song(1, 3);
        change_song(1);
        run_song(1, 0, 0, -1);

        // Full 32-note song, no marker
        fill_song(3, -1);
        change_song(3);
        run_song(3, 0, 0, -1);

        // Pause at index 4
        fill_song(0, -1);
        change_song(0);
        run_song(0, 0, 0, 4);

        // reset_player coinciding with note_done at index 7
        change_song(0);
        run_song(0, 1, 7, -1);
        run_song(0, 0, 0, -1);

        // Asynchronous reset mid-note, then restart from index 0
        fill_song(1, 20);
        change_song(1);
        run_song(1, 2, 2, -1);
        run_song(1, 0, 0, -1);

        // Randomised songs
        for (int k = 0; k < 5; k++) begin
            int s;
            int m;
            int p;
            s = int'($urandom_range(0, 3));
            m = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 31)) : -1;
            p = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 30)) : -1;
            fill_song(s, m);
            change_song(s);
            run_song(s, 0, 0, p);
        end

        repeat (4) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/song_reader.md
# song_reader

Song reader for the music player: it consumes the MCU's `play` / `reset_player` / `song` controls and walks the selected song's note ROM one note at a time. Each note is handed to the note player with a `new_note` strobe. When the song ends, `song_done` is returned to the MCU. It sits between the MCU and the song ROM / note player.

## Interface
Parameters:
- `NOTE_W`, 6, note code width; code 0 is reserved as part of the end-of-song marker.
- `DUR_W`, 6, note duration width, in note-player ticks.
- `IDX_W`, 5, note index width; 2^IDX_W notes per song.

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `play`  in  1  level from MCU; high = advance through song.
- `reset_player`  in  1  synchronous clear from MCU (song change / song end).
- `song`  in  2  song select from MCU.
- `rom_addr`  out  2+IDX_W  combinational `{song, index}`.
- `rom_data`  in  NOTE_W+DUR_W  `{note, duration}`; registered ROM, valid one cycle after `rom_addr`.
- `note_done`  in  1  pulse from note player: current note finished.
- `new_note`  out  1  one-cycle pulse: `note` / `duration` just updated.
- `note`  out  NOTE_W  current note, registered.
- `duration`  out  DUR_W  current duration, registered.
- `song_done`  out  1  one-cycle pulse: song finished.

## Operation
- Registered state: FSM state, `index` (IDX_W), `note`, `duration`, `new_note`.
- FSM states: IDLE, FETCH, LATCH, PLAY, DONE.
- **IDLE**
  - Stays in IDLE while `play`=0.
  - `play`=1 → FETCH.
- **FETCH**
  - ROM wait cycle, taken unconditionally → LATCH.
- **LATCH**
  - If `rom_data` == 0 (end marker): → DONE.
  - Otherwise: capture `note`/`duration`, set `new_note`=1 for the next cycle, → PLAY.
- **PLAY**
  - Holds the note while `note_done`=0, regardless of `play`; pausing is the note player's job.
  - On `note_done`=1 with `index` = 2^IDX_W−1: → DONE.
  - On `note_done`=1 otherwise: `index`+1, then → FETCH if `play`=1, else → IDLE.
- **DONE**
  - `song_done`=1, `index`←0, → IDLE unconditionally.
- `rom_addr` = `{song, index}` is valid in every state.
- `index` wraps only via DONE, never by natural overflow.
- `note`/`duration` hold their last value through IDLE and DONE.
- `reset_player`=1:
  - Highest priority over all FSM transitions, including a simultaneous `note_done` or end marker.
  - Next cycle: state IDLE, `index`=0, `note`=0, `duration`=0, `new_note`=0.
  - `song_done` is not generated.
- `song` changing without `reset_player` is not supported. The MCU always pulses `reset_player` on a song change.
- The MCU drives `reset_player` combinationally from `song_done`. The resulting same-cycle clear lands on the DONE→IDLE edge with `index`=0 and is harmless.

## Timing
- Reset (`reset_n`=0, async) values:
  - state IDLE, `index`=0, `note`=0, `duration`=0.
  - `new_note`=0, `song_done`=0, `rom_addr`={`song`,0}.
- `song_done` = (state==DONE): registered, glitch-free, exactly 1 cycle.
- `play` sampled high in IDLE at edge t: FETCH in t+1, LATCH in t+2, `new_note`=1 with the new `note` in t+3.
- `note_done` sampled in PLAY at edge k with `play`=1: next `new_note` at k+3.
- Last note's `note_done` at edge k: `song_done` high during cycle k+1.
- End marker seen in LATCH at edge k: `song_done` during cycle k+1, no `new_note`.
- `note_done` outside PLAY is ignored.
- `play` falling during FETCH/LATCH does not abort the fetch. The note is still issued, then held in PLAY.

## Test plan
- Reset then `play`=1, song 2, ROM[{2,0}]={5,10}: `rom_addr`=64; `new_note` pulses 3 cycles after `play`, `note`=5, `duration`=10.
- Three notes then ROM[{1,3}]=0 (marker), `play` held: three `new_note` pulses with ROM values, then one `song_done` pulse, `index`=0, IDLE.
- Full song, no marker, 32 notes, `note_done` each: 32 `new_note` pulses, `song_done` after 32nd `note_done`; `rom_addr` never exceeds `{song,31}`.
- `play`=0 at `note_done` on index 4: FSM parks in IDLE with `rom_addr` index 5; `play`=1 later yields note 5 three cycles after.
- `reset_player` on the same cycle as `note_done` at index 7: next cycle IDLE, `index`=0, `note`=0, no `song_done`, no `new_note`.
- `reset_n` asserted mid-PLAY asynchronously: outputs clear before the next clock edge; after release, `play` restarts from index 0.
